// File: rtl/ram_sp_ctrl_pkg.sv
// Shared types and helpers for the single-port RAM request controller.
package ram_sp_ctrl_pkg;

   // Controller sequencing states; IDLE is the only state that accepts requests.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_ADDR = 2'd2,
      RD_DATA = 2'd3
   } state_e;

   // rmw flag: set when a partially-enabled write is accepted. The read half
   // then runs as a normal read, but at the end of RD_DATA the fetched word is
   // merged with the pending write data and sent to WR instead of producing a
   // response. Cleared on every other accept.
   typedef logic rmw_t;

   // byte_merge works on the widest supported word; callers zero-extend their
   // DATA_WIDTH operands in and truncate the result back to DATA_WIDTH.
   localparam int MAX_DW = 1024;
   localparam int MAX_BW = MAX_DW / 8;

   // Per byte: take the new byte where be is set, keep the old byte elsewhere.
   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_BW-1:0] be
   );
      logic [MAX_DW-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_BW; i++)
         if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      return res;
   endfunction

endpackage

// File: rtl/ram_sp_ctrl.sv
// Request-side controller for the single-port synchronous RAM: sequences the
// registered RAM pins, owns the data bus while writing, does byte-masked
// writes as read-modify-write and returns read data on a valid/ready channel.
module ram_sp_ctrl
   import ram_sp_ctrl_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   parameter  int ADDR_WIDTH = 8,
   localparam int BE_WIDTH   = DATA_WIDTH / 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [BE_WIDTH-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   state_e                state_q, state_d;
   rmw_t                  rmw_q, rmw_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic                  cs_d, we_d, oe_d;
   logic                  rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_d;

   assign busy      = (state_q != IDLE);
   // A new request may only start when the response slot is free or draining.
   assign req_ready = (state_q == IDLE) && (!rsp_valid || rsp_ready);

   // Drive the bus only in write cycles; the RAM drives it only when we=0.
   assign ram_data  = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

   // Next-state and next-pin logic; pins default to deasserted, address holds.
   always_comb begin
      state_d     = state_q;
      rmw_d       = rmw_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      addr_d      = ram_address;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      oe_d        = 1'b0;
      rsp_valid_d = rsp_valid && !rsp_ready;
      rsp_rdata_d = rsp_rdata;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (!req_we) begin
                  state_d = RD_ADDR;
                  rmw_d   = 1'b0;
                  addr_d  = req_addr;
                  cs_d    = 1'b1;
                  oe_d    = 1'b1;
               end else if (&req_be) begin
                  state_d = WR;
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  cs_d    = 1'b1;
                  we_d    = 1'b1;
               end else if (|req_be) begin
                  state_d = RD_ADDR;
                  rmw_d   = 1'b1;
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  be_d    = req_be;
                  cs_d    = 1'b1;
                  oe_d    = 1'b1;
               end
               // be == 0 write: accepted and dropped, no RAM access.
            end
         end
         RD_ADDR: begin
            state_d = RD_DATA;
            cs_d    = 1'b1;
            oe_d    = 1'b1;
         end
         RD_DATA: begin
            if (rmw_q) begin
               state_d = WR;
               rmw_d   = 1'b0;
               wdata_d = DATA_WIDTH'(byte_merge(MAX_DW'(ram_data), MAX_DW'(wdata_q),
                                                MAX_BW'(be_q)));
               cs_d    = 1'b1;
               we_d    = 1'b1;
            end else begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = ram_data;
            end
         end
         WR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pin and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rmw_q       <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         ram_address <= '0;
         ram_cs      <= 1'b0;
         ram_we      <= 1'b0;
         ram_oe      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         state_q     <= state_d;
         rmw_q       <= rmw_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         ram_address <= addr_d;
         ram_cs      <= cs_d;
         ram_we      <= we_d;
         ram_oe      <= oe_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: directed scenarios followed by random traffic, with a
// behavioural RAM and a word-array reference model.
module tb_ram_sp_ctrl;

   localparam int DW = 64;
   localparam int AW = 8;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_be;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic [AW-1:0] ram_address;
   logic          ram_cs, ram_we, ram_oe;
   wire  [DW-1:0] ram_data;

   always #5 clk = ~clk;

   ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .busy(busy), .ram_address(ram_address), .ram_cs(ram_cs),
      .ram_we(ram_we), .ram_oe(ram_oe), .ram_data(ram_data)
   );

   // Behavioural single-port RAM: write on cs&we, registered read otherwise.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] ram_q = '0;
   always @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_address] <= ram_data;
      else if (ram_cs)      ram_q <= mem[ram_address];
   end
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

   // Reference: what each word should hold after every accepted write.
   logic [DW-1:0] ref_mem [256];
   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be);
      for (int b = 0; b < BW; b++)
         if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
   endtask

   // Starts and ends at posedge+1; returns in the first cycle after accept.
   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("req_timeout", DW'(req_ready), DW'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (we) model_write(a, d, be);
   endtask

   // Waits for the response, optionally holds it off for 'hold' cycles.
   task automatic recv(input string tag, input logic [DW-1:0] exp, input int hold);
      int n = 0;
      rsp_ready = (hold == 0);
      @(negedge clk);
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, DW'(rsp_valid), DW'(1));
      check(tag, rsp_rdata, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold"}, rsp_rdata, exp);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   // Whenever the controller writes, the RAM must not be output-enabled and
   // the bus must carry a known value.
   always @(negedge clk) begin
      if (rst_n && ram_cs && ram_we) begin
         check("bus_contention", DW'(ram_oe), DW'(0));
         check("bus_known", DW'($isunknown(ram_data)), DW'(0));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      int            bc;
      int            n;
      int            op;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [BW-1:0] be;

      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 1;
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs", DW'(ram_cs), DW'(0));
      check("rst_we", DW'(ram_we), DW'(0));
      check("rst_oe", DW'(ram_oe), DW'(0));
      check("rst_addr", DW'(ram_address), DW'(0));
      check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("rst_rdata", rsp_rdata, '0);
      check("rst_busy", DW'(busy), DW'(0));
      @(posedge clk); #1;
      rst_n = 1;

      // 1: full write then read with exact latency
      send(1, 8'h10, 64'h0123456789ABCDEF, 8'hFF);
      @(negedge clk);
      check("t1_wr_we", DW'(ram_we), DW'(1));
      check("t1_wr_cs", DW'(ram_cs), DW'(1));
      check("t1_wr_addr", DW'(ram_address), DW'(8'h10));
      check("t1_wr_bus", ram_data, 64'h0123456789ABCDEF);
      @(negedge clk);
      check("t1_wr_len", DW'(ram_we), DW'(0));
      check("t1_idle_busy", DW'(busy), DW'(0));
      @(posedge clk); #1;
      send(0, 8'h10, '0, '0);
      @(negedge clk);
      check("t1_lat1", DW'(rsp_valid), DW'(0));
      @(negedge clk);
      check("t1_lat2", DW'(rsp_valid), DW'(0));
      @(negedge clk);
      check("t1_lat3", DW'(rsp_valid), DW'(1));
      check("t1_rdata", rsp_rdata, 64'h0123456789ABCDEF);
      @(posedge clk); #1;

      // 2: partial write as read-modify-write
      send(1, 8'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      send(1, 8'h20, 64'h0, 8'h0F);
      bc = 0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (busy) bc++;
         if (ram_we) check("t2_merge_bus", ram_data, 64'hFFFFFFFF00000000);
         @(negedge clk);
      end
      check("t2_busy_cycles", DW'(bc), DW'(3));
      @(posedge clk); #1;
      send(0, 8'h20, '0, '0);
      recv("t2_rd", 64'hFFFFFFFF00000000, 0);

      // 3: response backpressure, then accept on the ready pulse
      rsp_ready = 0;
      send(0, 8'h10, '0, '0);
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t3_valid", DW'(rsp_valid), DW'(1));
      req_valid = 1; req_we = 0; req_addr = 8'h20;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("t3_stable", rsp_rdata, 64'h0123456789ABCDEF);
         check("t3_blocked", DW'(req_ready), DW'(0));
      end
      rsp_ready = 1; #1;
      check("t3_ready_pulse", DW'(req_ready), DW'(1));
      @(posedge clk); #1;
      req_valid = 0;
      check("t3_consumed", DW'(rsp_valid), DW'(0));
      check("t3_accepted", DW'(busy), DW'(1));
      recv("t3_rd2", 64'hFFFFFFFF00000000, 0);

      // 4: write with no byte enables is dropped
      send(1, 8'h30, {8{8'hAA}}, 8'hFF);
      send(1, 8'h30, {8{8'h55}}, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_no_cs", DW'(ram_cs), DW'(0));
         check("t4_no_busy", DW'(busy), DW'(0));
      end
      @(posedge clk); #1;
      send(0, 8'h30, '0, '0);
      recv("t4_rd", {8{8'hAA}}, 0);

      // 5: read immediately followed by write, no dead cycle
      send(1, 8'h40, {8{8'h5A}}, 8'hFF);
      send(0, 8'h40, '0, '0);
      @(negedge clk);
      @(negedge clk);
      req_valid = 1; req_we = 1; req_addr = 8'h40;
      req_wdata = {4{16'h1111}}; req_be = 8'hFF;
      @(negedge clk);
      check("t5_rd_valid", DW'(rsp_valid), DW'(1));
      check("t5_rd", rsp_rdata, {8{8'h5A}});
      check("t5_ready", DW'(req_ready), DW'(1));
      @(posedge clk); #1;
      req_valid = 0;
      model_write(8'h40, {4{16'h1111}}, 8'hFF);
      @(negedge clk);
      check("t5_wr_we", DW'(ram_we), DW'(1));
      check("t5_wr_oe", DW'(ram_oe), DW'(0));
      check("t5_wr_bus", ram_data, {4{16'h1111}});
      @(posedge clk); #1;
      send(0, 8'h40, '0, '0);
      recv("t5_rdback", {4{16'h1111}}, 0);

      // 6: reset during RD_DATA abandons the read
      send(0, 8'h10, '0, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      check("t6_rsp_valid", DW'(rsp_valid), DW'(0));
      check("t6_cs", DW'(ram_cs), DW'(0));
      check("t6_oe", DW'(ram_oe), DW'(0));
      check("t6_addr", DW'(ram_address), DW'(0));
      check("t6_busy", DW'(busy), DW'(0));
      check("t6_rdata", rsp_rdata, '0);
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_rsp", DW'(rsp_valid), DW'(0));
      end
      @(posedge clk); #1;
      send(0, 8'h10, '0, '0);
      recv("t6_rd", 64'h0123456789ABCDEF, 0);

      // Random traffic against the reference model
      for (int i = 0; i < 8; i++)
         send(1, 8'h80 + 8'(i), {$urandom, $urandom}, 8'hFF);
      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 3);
         a  = 8'h80 + 8'($urandom_range(0, 7));
         d  = {$urandom, $urandom};
         case (op)
            0: begin
               send(0, a, '0, '0);
               recv("rnd_rd", ref_mem[a], $urandom_range(0, 3));
            end
            1: send(1, a, d, 8'hFF);
            2: begin
               be = 8'($urandom_range(1, 254));
               send(1, a, d, be);
            end
            default: send(1, a, d, 8'h00);
         endcase
      end
      for (int i = 0; i < 8; i++) begin
         send(0, 8'h80 + 8'(i), '0, '0);
         recv("rnd_final", ref_mem[8'h80 + 8'(i)], 0);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
